// File: rtl/ins_loader_if.sv
// Serial-in stream plus instruction-memory write bus of the program loader.
interface ins_loader_if #(
  parameter int unsigned INS_W  = 9,
  parameter int unsigned ADDR_W = 4
);
  logic              ser_valid;
  logic              ser_in;
  logic              ready;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [INS_W-1:0]  WR_DATA;

  modport master (output ser_valid, ser_in, input ready, WR_EN, WR_ADDR, WR_DATA);
  modport slave  (input ser_valid, ser_in, output ready, WR_EN, WR_ADDR, WR_DATA);
endinterface

// File: rtl/ins_loader.sv
// Serial program loader: shifts MSB-first words into instruction memory, holding the CPU PC at
// START_PC until the load ends. Define INS_LOADER_PARITY_EN for a trailing even-parity bit and perr.
module ins_loader #(
  parameter int unsigned INS_W  = 9,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] START_PC,
  ins_loader_if.slave       bus,
  output logic              set_pc,
  output logic [ADDR_W-1:0] PC_INIT,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   WORDS
`ifdef INS_LOADER_PARITY_EN
  ,
  output logic              perr
`endif
);
`ifdef INS_LOADER_PARITY_EN
  localparam int unsigned SER_W = INS_W + 1;
`else
  localparam int unsigned SER_W = INS_W;
`endif
  localparam int unsigned CNT_W = $clog2(SER_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, RELEASE} state_t;

  state_t            state, state_d;
  logic [SER_W-2:0]  sreg, sreg_d;
  logic [SER_W-1:0]  word_c;
  logic [INS_W-1:0]  data_c;
  logic              ok_c;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic              set_pc_q, set_pc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] pc_init_q, pc_init_d;
  logic [INS_W-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W:0]   words_q, words_d;
`ifdef INS_LOADER_PARITY_EN
  logic              perr_q, perr_d;
`endif

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      set_pc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      pc_init_q <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
`ifdef INS_LOADER_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      sreg      <= sreg_d;
      cnt       <= cnt_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      set_pc_q  <= set_pc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_addr_q <= wr_addr_d;
      pc_init_q <= pc_init_d;
      wr_data_q <= wr_data_d;
      words_q   <= words_d;
`ifdef INS_LOADER_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_d   = state;
    sreg_d    = sreg;
    cnt_d     = cnt;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pc_init_d = pc_init_q;
    words_d   = words_q;
    word_c    = {sreg, bus.ser_in};
    data_c    = word_c[SER_W-1 -: INS_W];
`ifdef INS_LOADER_PARITY_EN
    perr_d    = perr_q;
    ok_c      = ((^data_c) == word_c[0]);
`else
    ok_c      = 1'b1;
`endif

    unique case (state)
      IDLE: state_d = IDLE;
      SHIFT: begin
        // stop is only honoured between words; it wins over a bit arriving the same cycle
        if (stop && (cnt == CNT_W'(0))) begin
          state_d = RELEASE;
        end else if (bus.ser_valid) begin
          sreg_d = word_c[SER_W-2:0];
          if (cnt == CNT_W'(SER_W - 1)) begin
            state_d   = WRITE;
            cnt_d     = CNT_W'(0);
            wr_data_d = data_c;
            wr_en_d   = ok_c;
`ifdef INS_LOADER_PARITY_EN
            perr_d    = perr_q | ~ok_c;
`endif
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        // A rejected word leaves the address and count where they were
        if (wr_en_q) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          words_d   = words_q + (ADDR_W+1)'(1);
        end
        state_d = (words_d == (ADDR_W+1)'(DEPTH)) ? RELEASE : SHIFT;
      end
      RELEASE: state_d = IDLE;
    endcase

    // Restart from any state discards the partial word and any pending write
    if (start) begin
      state_d   = SHIFT;
      cnt_d     = CNT_W'(0);
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      wr_addr_d = '0;
      words_d   = '0;
      pc_init_d = START_PC;
`ifdef INS_LOADER_PARITY_EN
      perr_d    = 1'b0;
`endif
    end

    ready_d  = (state_d == SHIFT);
    busy_d   = (state_d != IDLE);
    set_pc_d = (state_d != IDLE);
    done_d   = (state_d == RELEASE);
  end

  assign bus.ready   = ready_q;
  assign bus.WR_EN   = wr_en_q;
  assign bus.WR_ADDR = wr_addr_q;
  assign bus.WR_DATA = wr_data_q;
  assign set_pc      = set_pc_q;
  assign PC_INIT     = pc_init_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign WORDS       = words_q;
`ifdef INS_LOADER_PARITY_EN
  assign perr        = perr_q;
`endif

endmodule

// File: doc/ins_loader.md
Name: ins_loader

Overview:
- Serial program loader for the 4-bit CPU instruction memory.
- Shifts in 9-bit instruction words MSB-first from a host bit stream and writes them into consecutive instruction-memory addresses.
- Holds the CPU program counter at a start address via set_pc for the whole load, then releases it.
- It is the write side of the instruction memory, which the PC/decode path only reads.

Parameters:
- INS_W, 9, instruction word width in bits; matches the instruction-memory data width.
- ADDR_W, 4, instruction address width; matches PC width.
- DEPTH, 16, number of instruction-memory words (2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: begin a new load at address 0.
- stop  input  1  end load early; sampled only on a word boundary.
- ser_valid  input  1  ser_in carries a valid bit this cycle.
- ser_in  input  1  serial instruction bit, MSB first.
- START_PC  input  ADDR_W  address the CPU starts from after the load.
- ready  output  1  loader accepts a serial bit this cycle.
- WR_EN  output  1  instruction-memory write strobe.
- WR_ADDR  output  ADDR_W  instruction-memory write address.
- WR_DATA  output  INS_W  instruction-memory write data.
- set_pc  output  1  drives the CPU PC load input.
- PC_INIT  output  ADDR_W  drives the CPU PC load value.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse when the load completes.
- WORDS  output  ADDR_W+1  number of words written in the last or current load.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; WR_EN=0; WR_ADDR=0; WR_DATA=0; set_pc=0; PC_INIT=0; busy=0; done=0; ready=0; WORDS=0; bit counter=0.
- IDLE:
  - ready=0, busy=0.
  - start=1 -> SHIFT; WR_ADDR=0, WORDS=0, bit count=0; PC_INIT captures START_PC.
- SHIFT:
  - ready=1, busy=1, set_pc=1.
  - Each cycle with ser_valid=1: shift register <= {shift[INS_W-2:0], ser_in}; bit count +1.
  - When the INS_W-th bit is accepted -> WRITE next cycle.
  - stop=1 while bit count=0 -> RELEASE. stop with bit count≠0 is ignored.
  - ser_valid=0 holds all state.
- WRITE (exactly 1 cycle):
  - WR_EN=1; WR_DATA=assembled word; ready=0, so ser_valid is ignored.
  - Next cycle: WR_ADDR +1 and WORDS +1.
  - If WORDS reaches DEPTH -> RELEASE (WR_ADDR wraps to 0, not used further).
  - Otherwise -> SHIFT with bit count=0.
  - Write latency: last bit accepted at cycle N -> WR_EN high at cycle N+1.
- RELEASE (1 cycle):
  - set_pc=1 with PC_INIT=captured START_PC, so the PC loads the start address.
  - done=1; next state IDLE.
  - set_pc drops to 0 in IDLE and the CPU runs.
- set_pc is 1 in SHIFT, WRITE and RELEASE, and 0 in IDLE.
- start in any non-IDLE state restarts the load: any partial word is discarded, no write occurs that cycle, WR_ADDR=0, WORDS=0, and START_PC is re-captured. start has priority over stop and over completion of the INS_W-th bit.
- start and stop together in IDLE: start wins.
- Reset mid-load: immediate return to reset values; the CPU PC is released (set_pc=0). Words already written remain in memory.
- WORDS is held in IDLE until the next start.

Optional Feature:
- Macro: INS_LOADER_PARITY_EN.
- Defined:
  - Each word is INS_W+1 bits; the final bit is even parity over the INS_W data bits.
  - On mismatch, WRITE does not assert WR_EN and WR_ADDR/WORDS do not advance.
  - Extra output perr (1 bit) sets sticky, cleared by start or reset; its reset value is 0.
- Undefined: words are INS_W bits, no parity bit is consumed, and the perr port does not exist.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0 asynchronously; no WR_EN while idle with ser_valid toggling.
- Three-word load: start with START_PC=4'h2, stream 9'h1A5, 9'h003, 9'h1FF, then stop -> WR_EN at addresses 0,1,2 with those data; RELEASE has set_pc=1, PC_INIT=2, done=1; WORDS=3.
- Full memory: stream 16 words (value = address) with no stop -> 16 writes, automatic RELEASE after address 15, WORDS=16.
- Gapped stream: ser_valid low for 5 cycles mid-word -> same 9'h0B6 written once, write delayed by 5 cycles.
- Restart and stop: start after 4 bits of a word -> no write, next word goes to address 0; stop with 3 bits pending ignored, then honoured on the boundary.
- Parity (INS_LOADER_PARITY_EN): 9'h0F0 with parity bit 1 -> no WR_EN, perr=1, next good word written at the same address.
